// File: rtl/pong_pkg.sv
// Shared FSM state, direction encodings, default playfield geometry and the
// saturating 11-bit coordinate helpers used by the pong ball engine.
package pong_pkg;

  typedef enum logic [1:0] {
    SERVE_WAIT = 2'd0,
    MOVE       = 2'd1,
    SCORED     = 2'd2,
    DONE       = 2'd3
  } state_e;

  typedef enum logic {
    DX_LEFT  = 1'b0,
    DX_RIGHT = 1'b1
  } dx_e;

  typedef enum logic {
    DY_UP   = 1'b0,
    DY_DOWN = 1'b1
  } dy_e;

  localparam int unsigned X_MAX_DEF      = 639;
  localparam int unsigned Y_MAX_DEF      = 479;
  localparam int unsigned BALL_R_DEF     = 5;
  localparam int unsigned P1_X_DEF       = 35;
  localparam int unsigned P2_X_DEF       = 605;
  localparam int unsigned PAD_HALF_DEF   = 45;
  localparam int unsigned SPEED_INIT_DEF = 4;
  localparam int unsigned SPEED_MAX_DEF  = 12;
  localparam int unsigned WIN_SCORE_DEF  = 9;

  // One spare bit above the 10-bit screen range so sums never wrap.
  localparam int COORD_W = 11;
  localparam int SPEED_W = 4;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [SPEED_W-1:0] speed_t;

  function automatic coord_t abs_diff(input coord_t a, input coord_t b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic coord_t sat_sub(input coord_t a, input coord_t b);
    return (a > b) ? (a - b) : '0;
  endfunction

  function automatic coord_t sat_add(input coord_t a, input coord_t b, input coord_t lim);
    return ((a + b) > lim) ? lim : (a + b);
  endfunction

  function automatic logic [9:0] to_pix(input coord_t v);
    return (v > coord_t'(1023)) ? 10'h3FF : v[9:0];
  endfunction

endpackage

// File: rtl/pong_score_counter.sv
// Saturating 4-bit player score with synchronous clear and a reached-win flag.
module pong_score_counter
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE = WIN_SCORE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clear,
  output logic [3:0] count,
  output logic       reaches_win
);

  localparam logic [3:0] WIN_C = 4'(WIN_SCORE);

  logic [3:0] count_q, count_d;

  always_comb begin
    // NOTE: default first, so no path through this block leaves count_d unassigned (no latch).
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != 4'hF)) begin
      count_d = count_q + 4'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count       = count_q;
  assign reaches_win = (count_q == WIN_C);

endmodule

// File: rtl/pong_ball_engine.sv
// Pong ball engine: serve/move/score FSM, wall and paddle bounces, ball overlay.
// Define BALL_SPEEDUP_EN to make each paddle hit raise the ball speed up to SPEED_MAX.
module pong_ball_engine
  import pong_pkg::*;
#(
  parameter int unsigned X_MAX      = X_MAX_DEF,
  parameter int unsigned Y_MAX      = Y_MAX_DEF,
  parameter int unsigned BALL_R     = BALL_R_DEF,
  parameter int unsigned P1_X       = P1_X_DEF,
  parameter int unsigned P2_X       = P2_X_DEF,
  parameter int unsigned PAD_HALF   = PAD_HALF_DEF,
  parameter int unsigned SPEED_INIT = SPEED_INIT_DEF,
  parameter int unsigned SPEED_MAX  = SPEED_MAX_DEF,
  parameter int unsigned WIN_SCORE  = WIN_SCORE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       serve,
  input  logic [9:0] p1_position,
  input  logic [9:0] p2_position,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       b_display,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       hit,
  output logic       point,
  output logic       game_over
);

  localparam coord_t CX    = coord_t'((X_MAX + 1) / 2);
  localparam coord_t CY    = coord_t'((Y_MAX + 1) / 2);
  localparam coord_t X_LIM = coord_t'(X_MAX);
  localparam coord_t Y_LIM = coord_t'(Y_MAX);
  localparam coord_t R_C   = coord_t'(BALL_R);
  localparam coord_t Y_TOP = coord_t'(BALL_R);
  localparam coord_t Y_BOT = coord_t'(Y_MAX - BALL_R);
  localparam coord_t P1_C  = coord_t'(P1_X);
  localparam coord_t P2_C  = coord_t'(P2_X);
  localparam coord_t PAD_C = coord_t'(PAD_HALF);
  localparam speed_t SPEED_START =
    speed_t'((SPEED_INIT < SPEED_MAX) ? SPEED_INIT : SPEED_MAX);

  state_e     state_q, state_d;
  logic [9:0] ball_x_q, ball_x_d;
  logic [9:0] ball_y_q, ball_y_d;
  dx_e        dx_q, dx_d;
  dy_e        dy_q, dy_d;
  dx_e        serve_dir_q, serve_dir_d;
  logic       hit_q, hit_d;
  logic       point_q, point_d;

  coord_t bx, by, px, py, p1_row, p2_row, pad_row, spd, nx, ny;
  dx_e    ndx;
  dy_e    ndy;
  logic   at_paddle, on_paddle;
  logic   p1_inc, p2_inc, score_clr, p1_win, p2_win;
  speed_t speed;

  assign bx     = coord_t'(ball_x_q);
  assign by     = coord_t'(ball_y_q);
  assign px     = coord_t'(pixel_x);
  assign py     = coord_t'(pixel_y);
  assign p1_row = coord_t'(p1_position);
  assign p2_row = coord_t'(p2_position);
  assign spd    = coord_t'(speed);

`ifdef BALL_SPEEDUP_EN
  localparam speed_t SPEED_CEIL = speed_t'(SPEED_MAX);

  speed_t speed_q, speed_d;

  always_comb begin
    speed_d = speed_q;
    if ((state_q == SERVE_WAIT) && serve) begin
      speed_d = SPEED_START;
    end else if ((state_q == MOVE) && tick && at_paddle && on_paddle && (speed_q < SPEED_CEIL)) begin
      speed_d = speed_q + speed_t'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      speed_q <= SPEED_START;
    end else begin
      speed_q <= speed_d;
    end
  end

  assign speed = speed_q;
`else
  assign speed = SPEED_START;
`endif

  // Candidate next position/direction for one tick of motion; the FSM decides whether to commit it.
  always_comb begin
    ny  = by;
    ndy = dy_q;
    if (dy_q == DY_UP) begin
      if (by <= (Y_TOP + spd)) begin
        ny  = Y_TOP;
        ndy = DY_DOWN;
      end else begin
        ny = sat_sub(by, spd);
      end
    end else begin
      if ((by + spd) >= Y_BOT) begin
        ny  = Y_BOT;
        ndy = DY_UP;
      end else begin
        ny = sat_add(by, spd, Y_LIM);
      end
    end

    pad_row   = (dx_q == DX_LEFT) ? p1_row : p2_row;
    at_paddle = (dx_q == DX_LEFT) ? (bx <= (P1_C + spd)) : ((bx + spd) >= P2_C);
    on_paddle = (abs_diff(by, pad_row) <= PAD_C);

    nx  = (dx_q == DX_LEFT) ? sat_sub(bx, spd) : sat_add(bx, spd, X_LIM);
    ndx = dx_q;
    // A paddle hit overrides the wall's vertical direction but keeps its row.
    if (at_paddle && on_paddle) begin
      nx  = (dx_q == DX_LEFT) ? P1_C : P2_C;
      ndx = (dx_q == DX_LEFT) ? DX_RIGHT : DX_LEFT;
      ndy = (by < pad_row) ? DY_UP : DY_DOWN;
    end
  end

  always_comb begin
    state_d     = state_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    serve_dir_d = serve_dir_q;
    hit_d       = 1'b0;
    point_d     = 1'b0;
    p1_inc      = 1'b0;
    p2_inc      = 1'b0;
    score_clr   = 1'b0;

    unique case (state_q)
      SERVE_WAIT: begin
        ball_x_d = to_pix(CX);
        ball_y_d = to_pix(CY);
        if (serve) begin
          state_d = MOVE;
          dx_d    = serve_dir_q;
          dy_d    = DY_DOWN;
        end
      end

      MOVE: begin
        if (tick) begin
          ball_x_d = to_pix(nx);
          ball_y_d = to_pix(ny);
          dx_d     = ndx;
          dy_d     = ndy;
          if (at_paddle && on_paddle) begin
            hit_d = 1'b1;
          end else if (at_paddle) begin
            point_d = 1'b1;
            state_d = SCORED;
            // The next serve heads toward whoever just lost the point.
            if (dx_q == DX_LEFT) begin
              p2_inc      = 1'b1;
              serve_dir_d = DX_LEFT;
            end else begin
              p1_inc      = 1'b1;
              serve_dir_d = DX_RIGHT;
            end
          end
        end
      end

      SCORED: begin
        if (tick) begin
          ball_x_d = to_pix(CX);
          ball_y_d = to_pix(CY);
          state_d  = (p1_win || p2_win) ? DONE : SERVE_WAIT;
        end
      end

      DONE: begin
        ball_x_d = to_pix(CX);
        ball_y_d = to_pix(CY);
        if (serve) begin
          score_clr = 1'b1;
          state_d   = SERVE_WAIT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SERVE_WAIT;
      ball_x_q    <= to_pix(CX);
      ball_y_q    <= to_pix(CY);
      dx_q        <= DX_LEFT;
      dy_q        <= DY_DOWN;
      serve_dir_q <= DX_LEFT;
      hit_q       <= 1'b0;
      point_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      serve_dir_q <= serve_dir_d;
      hit_q       <= hit_d;
      point_q     <= point_d;
    end
  end

  pong_score_counter #(.WIN_SCORE(WIN_SCORE)) u_p1_score (
    .clk         (clk),
    .reset       (reset),
    .inc         (p1_inc),
    .clear       (score_clr),
    .count       (p1_score),
    .reaches_win (p1_win)
  );

  pong_score_counter #(.WIN_SCORE(WIN_SCORE)) u_p2_score (
    .clk         (clk),
    .reset       (reset),
    .inc         (p2_inc),
    .clear       (score_clr),
    .count       (p2_score),
    .reaches_win (p2_win)
  );

  // Sums on both sides avoid an unsigned underflow near the screen edges.
  assign b_display = ((px + R_C) >= bx) && ((bx + R_C) >= px) &&
                     ((py + R_C) >= by) && ((by + R_C) >= py);

  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign hit       = hit_q;
  assign point     = point_q;
  assign game_over = (state_q == DONE);

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed self-checking bench for pong_ball_engine with default geometry.
module tb_pong_ball_engine;

`ifdef BALL_SPEEDUP_EN
  localparam int SPD_HIT   = 5;
  localparam int WALL_PRE  = 83;
  localparam int PRE_X     = 450;
  localparam int PRE_Y     = 7;
  localparam int SPD_FINAL = 12;
`else
  localparam int SPD_HIT   = 4;
  localparam int WALL_PRE  = 104;
  localparam int PRE_X     = 451;
  localparam int PRE_Y     = 6;
  localparam int SPD_FINAL = 4;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       serve = 1'b0;
  logic [9:0] p1_position = 10'd240;
  logic [9:0] p2_position = 10'd240;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic [9:0] ball_x, ball_y;
  logic       b_display, hit, point, game_over;
  logic [3:0] p1_score, p2_score;

  int checks = 0;
  int errors = 0;

  pong_ball_engine dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .serve       (serve),
    .p1_position (p1_position),
    .p2_position (p2_position),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .b_display   (b_display),
    .p1_score    (p1_score),
    .p2_score    (p2_score),
    .hit         (hit),
    .point       (point),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  task automatic do_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic do_serve();
    @(negedge clk); serve = 1'b1;
    @(negedge clk); serve = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_ball(input string name, input int ex, input int ey);
    checks++;
    if (ball_x !== 10'(ex) || ball_y !== 10'(ey)) begin
      errors++;
      $display("FAIL %s: got (%0d,%0d) expected (%0d,%0d)", name, ball_x, ball_y, ex, ey);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_ball("reset_ball", 320, 240);
    checks++;
    if ({p1_score, p2_score, hit, point, game_over} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got p1=%0d p2=%0d hit=%b point=%b go=%b expected all 0",
               p1_score, p2_score, hit, point, game_over);
    end
    reset = 1'b1;
    @(negedge clk);
    do_tick();
    check_ball("serve_wait_hold", 320, 240);
  endtask

  task automatic test_display();
    int vx[9] = '{320, 315, 325, 314, 320, 326, 320, 320, 0};
    int vy[9] = '{240, 235, 245, 240, 246, 240, 234, 235, 0};
    logic ve[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      pixel_x = 10'(vx[i]);
      pixel_y = 10'(vy[i]);
      #1;
      checks++;
      if (b_display !== ve[i]) begin
        errors++;
        $display("FAIL display_%0d: pixel (%0d,%0d) got %b expected %b", i, vx[i], vy[i], b_display, ve[i]);
      end
    end
  endtask

  task automatic test_serve_move();
    do_serve();
    do_tick();
    check_ball("serve_tick1", 316, 244);
    do_tick();
    check_ball("serve_tick2", 312, 248);
  endtask

  task automatic test_paddle_hit();
    p1_position = 10'd436;
    tick_n(69);
    check_ball("pre_hit", 36, 426);
    do_tick();
    checks++;
    if (hit !== 1'b1) begin
      errors++;
      $display("FAIL hit_pulse: got %b expected 1", hit);
    end
    check_ball("hit_pos", 35, 422);
    @(negedge clk);
    checks++;
    if (hit !== 1'b0) begin
      errors++;
      $display("FAIL hit_pulse_end: got %b expected 0", hit);
    end
    do_tick();
    check_ball("after_hit", 35 + SPD_HIT, 422 - SPD_HIT);
  endtask

  task automatic test_top_wall();
    tick_n(WALL_PRE - 1);
    check_ball("pre_wall", PRE_X, PRE_Y);
    do_tick();
    check_ball("wall_clamp", 455, 5);
    pixel_x = 10'd455; pixel_y = 10'd0; #1;
    checks++;
    if (b_display !== 1'b1) begin
      errors++;
      $display("FAIL display_top_edge: got %b expected 1", b_display);
    end
    pixel_x = 10'd461; pixel_y = 10'd2; #1;
    checks++;
    if (b_display !== 1'b0) begin
      errors++;
      $display("FAIL display_right_off: got %b expected 0", b_display);
    end
    do_tick();
    check_ball("wall_down", 455 + SPD_HIT, 5 + SPD_HIT);
  endtask

  task automatic test_paddle_boundary();
    apply_reset();
    do_serve(); p1_position = 10'd381;
    tick_n(72);
    checks++;
    if (hit !== 1'b1) begin
      errors++;
      $display("FAIL hit_edge45: got %b expected 1", hit);
    end
    do_tick();
    check_ball("hit_below_dy_down", 35 + SPD_HIT, 422 + SPD_HIT);
    apply_reset();
    do_serve(); p1_position = 10'd380;
    tick_n(72);
    checks++;
    if (hit !== 1'b0 || point !== 1'b1) begin
      errors++;
      $display("FAIL miss_edge46: got hit=%b point=%b expected hit=0 point=1", hit, point);
    end
  endtask

  task automatic test_miss();
    apply_reset();
    do_serve(); p1_position = 10'd50;
    tick_n(72);
    checks++;
    if (point !== 1'b1 || p2_score !== 4'd1 || p1_score !== 4'd0) begin
      errors++;
      $display("FAIL miss_score: got point=%b p1=%0d p2=%0d expected 1,0,1", point, p1_score, p2_score);
    end
    @(negedge clk);
    checks++;
    if (point !== 1'b0) begin
      errors++;
      $display("FAIL point_pulse_end: got %b expected 0", point);
    end
    do_tick();
    check_ball("scored_recentre", 320, 240);
    do_tick();
    check_ball("serve_wait_after_point", 320, 240);
    do_serve();
    do_tick();
    check_ball("serve_left_after_p1_loss", 316, 244);
  endtask

  task automatic test_game_over();
    int n = 0;
    apply_reset();
    do_serve(); p1_position = 10'd436; p2_position = 10'd50;
    while (point !== 1'b1 && n < 400) begin
      do_tick();
      n++;
    end
    checks++;
    if (point !== 1'b1 || p1_score !== 4'd1) begin
      errors++;
      $display("FAIL rally1: got point=%b p1=%0d expected 1,1", point, p1_score);
    end
    do_tick();
    for (int i = 2; i <= 9; i++) begin
      do_serve();
      do_tick();
      if (i == 2) check_ball("serve_right_after_p2_loss", 324, 244);
      tick_n(71);
      checks++;
      if (point !== 1'b1 || p1_score !== 4'(i) || p2_score !== 4'd0) begin
        errors++;
        $display("FAIL right_miss_%0d: got point=%b p1=%0d p2=%0d expected 1,%0d,0",
                 i, point, p1_score, p2_score, i);
      end
      do_tick();
      checks++;
      if (game_over !== (i == 9)) begin
        errors++;
        $display("FAIL game_over_%0d: got %b expected %b", i, game_over, (i == 9));
      end
    end
    check_ball("done_centred", 320, 240);
    tick_n(3);
    checks++;
    if (game_over !== 1'b1 || p1_score !== 4'd9) begin
      errors++;
      $display("FAIL done_frozen: got go=%b p1=%0d expected 1,9", game_over, p1_score);
    end
    do_serve();
    checks++;
    if (game_over !== 1'b0 || p1_score !== 4'd0 || p2_score !== 4'd0) begin
      errors++;
      $display("FAIL done_serve_clear: got go=%b p1=%0d p2=%0d expected 0,0,0", game_over, p1_score, p2_score);
    end
    do_tick();
    check_ball("done_serve_waits", 320, 240);
  endtask

  task automatic test_reset_mid_move();
    int hits = 0;
    int n = 0;
    int x0;
    int delta;
    p2_position = 10'd50;
    do_serve();
    tick_n(72);
    checks++;
    if (p1_score !== 4'd1) begin
      errors++;
      $display("FAIL pre_reset_score: got %0d expected 1", p1_score);
    end
    do_tick();
    do_serve();
    tick_n(5);
    check_ball("mid_move", 340, 260);
    #2 reset = 1'b0;
    #1;
    check_ball("async_reset_ball", 320, 240);
    checks++;
    if ({p1_score, p2_score, hit, point, game_over} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset_outputs: got p1=%0d p2=%0d hit=%b point=%b go=%b expected all 0",
               p1_score, p2_score, hit, point, game_over);
    end
    @(negedge clk); reset = 1'b1;
    do_serve();
    do_tick();
    check_ball("serve_left_after_reset", 316, 244);
    while (hits < 20 && n < 20000) begin
      p1_position = ball_y; p2_position = ball_y;
      do_tick();
      if (hit === 1'b1) hits++;
      n++;
    end
    checks++;
    if (hits != 20) begin
      errors++;
      $display("FAIL twenty_hits: got %0d hits expected 20", hits);
    end
    n = 0;
    while ((ball_x < 10'd100 || ball_x > 10'd500) && n < 200) begin
      p1_position = ball_y; p2_position = ball_y;
      do_tick();
      n++;
    end
    x0 = int'(ball_x);
    do_tick();
    delta = (int'(ball_x) > x0) ? int'(ball_x) - x0 : x0 - int'(ball_x);
    checks++;
    if (delta != SPD_FINAL) begin
      errors++;
      $display("FAIL speed_after_20_hits: got %0d expected %0d", delta, SPD_FINAL);
    end
  endtask

  initial begin
    test_reset();
    test_display();
    test_serve_move();
    test_paddle_hit();
    test_top_wall();
    test_paddle_boundary();
    test_miss();
    test_game_over();
    test_reset_mid_move();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_ball_engine.md
PONG_BALL_ENGINE -- requirements
Module: pong_ball_engine

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  X_MAX  639  rightmost playfield column
  Y_MAX  479  bottom playfield row; top row is 0
  BALL_R  5  ball half-size in pixels
  P1_X  35  left paddle contact column
  P2_X  605  right paddle contact column
  PAD_HALF  45  paddle half-height
  SPEED_INIT  4  pixels per tick after every serve
  SPEED_MAX  12  speed ceiling
  WIN_SCORE  9  points that end the game (1..15)
REQ-002 Ports, one per line: name  direction  width  meaning.
  clk  in  1  single system clock
  reset  in  1  asynchronous, active-low reset
  tick  in  1  one-cycle game-update strobe, synchronous to clk
  serve  in  1  one-cycle serve/restart request
  p1_position  in  10  left paddle centre row
  p2_position  in  10  right paddle centre row
  pixel_x  in  10  current VGA column
  pixel_y  in  10  current VGA row
  ball_x  out  10  ball centre column
  ball_y  out  10  ball centre row
  b_display  out  1  current pixel lies inside the ball square
  p1_score  out  4  left player score
  p2_score  out  4  right player score
  hit  out  1  one-cycle pulse on any paddle hit
  point  out  1  one-cycle pulse on any score
  game_over  out  1  high while in DONE

Function
REQ-003 States: SERVE_WAIT, MOVE, SCORED, DONE; reset enters SERVE_WAIT.
REQ-004 Ball position, direction, speed and state change only on clk edges where tick=1, except serve handling and pulses, which act on any clk edge.
REQ-005 SERVE_WAIT: ball held at (X_MAX+1)/2, (Y_MAX+1)/2; serve=1 moves to MOVE next cycle with speed=SPEED_INIT, dy=down, dx toward the player who lost the last point (left after reset).
REQ-006 MOVE, per tick: ball_x +/- speed, ball_y +/- speed per dx/dy sign; all arithmetic in 11 bits, result clamped, never wraps.
REQ-007 Wall: moving up with ball_y <= BALL_R+speed -> ball_y=BALL_R, dy flips; moving down with ball_y >= Y_MAX-BALL_R-speed -> ball_y=Y_MAX-BALL_R, dy flips.
REQ-008 Paddle: moving left with ball_x <= P1_X+speed -> hit if |ball_y-p1_position| <= PAD_HALF, else miss; right side symmetric with P2_X, p2_position.
REQ-009 On hit: ball_x=paddle column, dx flips, dy=up if ball_y < paddle centre else down, hit pulses one cycle, speed increments per REQ-016.
REQ-010 Wall and paddle events in the same tick both apply; paddle rule sets dy.
REQ-011 On miss: opponent score +1, point pulses one cycle, state -> SCORED.
REQ-012 SCORED, next tick: any score = WIN_SCORE -> DONE, else -> SERVE_WAIT with ball recentred.
REQ-013 DONE: game_over=1, ball centred, scores frozen; serve clears both scores, -> SERVE_WAIT.
REQ-014 b_display combinational: |pixel_x-ball_x| <= BALL_R and |pixel_y-ball_y| <= BALL_R, computed without unsigned underflow.

Reset
REQ-015 reset=0 asynchronously forces state SERVE_WAIT, ball centred, scores 0, speed SPEED_INIT, hit/point/game_over 0, serve direction left; applies mid-move or mid-DONE alike.

Configuration
REQ-016 BALL_SPEEDUP_EN defined: each hit raises speed by 1, saturating at SPEED_MAX; undefined: speed stays SPEED_INIT, speed register removed.

Structure
REQ-017 Package pong_pkg holds the state enum, direction encodings and default geometry constants.
REQ-018 Sub-module pong_score_counter (saturating 4-bit counter, inc/clear, reaches_win flag), instantiated once per player.

Verification
REQ-019 Release reset, serve, ticks -> ball moves left 4/tick, down 4/tick from (320,240).
REQ-020 Ball reaches P1_X with p1_position=ball_y+10 -> hit pulse, dx right, dy up; with BALL_SPEEDUP_EN speed 5.
REQ-021 Ball at ball_y=7 moving up, speed 4 -> next tick ball_y=5, dy down.
REQ-022 p1_position=50, ball at P1_X row 400 -> p2_score 1, point pulse, SERVE_WAIT, ball (320,240), next serve goes left.
REQ-023 p1_score 8, right-side miss -> p1_score 9, DONE, game_over=1; serve -> scores 0, SERVE_WAIT.
REQ-024 reset asserted mid-MOVE between clk edges -> outputs at reset values immediately, 20 hits at SPEED_MAX stay 12.
